// File: rtl/muldiv_hilo_unit_if.sv
// Issue/result bundle between decode/execute and the HI/LO multiply-divide unit.
// The master drives the issue side; the slave (the unit) returns busy/done and HI/LO.
interface muldiv_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       func;
  logic [WIDTH-1:0] rsData;
  logic [WIDTH-1:0] rtData;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, func, rsData, rtData, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, func, rsData, rtData, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO: one 64-bit shift register
// serves as the shift-add product accumulator or as the {remainder, quotient} pair.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  muldiv_hilo_unit_if.slave bus
);
  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic               div_zero_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               func_valid, accept, op_div, op_signed;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH-1:0] acc_step, prod_fix;
  logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;

  // Function codes 011000..011011: bit 1 selects divide, bit 0 selects unsigned.
  assign func_valid = (bus.func[5:2] == 4'b0110);
  assign op_div     = bus.func[1];
  assign op_signed  = ~bus.func[0];
  assign accept     = (state_q == IDLE) && bus.start && !bus.flush && func_valid;

  assign rs_mag = (op_signed && bus.rsData[WIDTH-1]) ? (~bus.rsData + 1'b1) : bus.rsData;
  assign rt_mag = (op_signed && bus.rtData[WIDTH-1]) ? (~bus.rtData + 1'b1) : bus.rtData;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC: begin
        if (bus.flush)           state_d = IDLE;
        else if (cnt_q == LAST)  state_d = FIXUP;
      end
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Remainder never exceeds the divisor, so the 33-bit trial fits back into 32 bits.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign trial   = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_q};

  always_comb begin
    acc_step = acc_q;
    if (is_div_q) begin
      if (trial[WIDTH+1]) acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
      else                acc_step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      if (acc_q[0]) acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      else          acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  // Sign restore; the |rs| remainder of a divide-by-zero negates back to rs itself.
  assign prod_fix = neg_quo_q ? (~acc_q + 1'b1) : acc_q;
  assign quot     = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];
  assign res_lo   = !is_div_q  ? prod_fix[WIDTH-1:0] :
                    div_zero_q ? {WIDTH{1'b1}} :
                    neg_quo_q  ? (~quot + 1'b1) : quot;
  assign res_hi   = !is_div_q  ? prod_fix[2*WIDTH-1:WIDTH] :
                    neg_rem_q  ? (~rem + 1'b1) : rem;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        cnt_q      <= '0;
        acc_q      <= {{WIDTH{1'b0}}, (op_div ? rs_mag : rt_mag)};
        opnd_q     <= op_div ? rt_mag : rs_mag;
        is_div_q   <= op_div;
        neg_quo_q  <= op_signed & (bus.rsData[WIDTH-1] ^ bus.rtData[WIDTH-1]);
        neg_rem_q  <= op_signed & bus.rsData[WIDTH-1];
        div_zero_q <= (bus.rtData == '0);
      end else if (state_q == CALC && !bus.flush) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 1'b1;
      end else if (state_q == FIXUP && !bus.flush) begin
        hi_q   <= res_hi;
        lo_q   <= res_lo;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Bench for muldiv_hilo_unit: latency-counter reference model compared every cycle,
// directed literal cases, control events, then randomized issue/flush traffic.
module tb_muldiv_hilo_unit;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  muldiv_hilo_unit_if #(.WIDTH(32)) bus ();

  muldiv_hilo_unit #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  // Architectural result {HI, LO} straight from the arithmetic definition.
  function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    case (f)
      F_MULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      F_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        return up;
      end
      F_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      end
      F_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Reference model: an accepted op becomes visible 33 edges later unless flushed.
  int          m_rem   = 0;
  logic [31:0] m_hi    = '0;
  logic [31:0] m_lo    = '0;
  logic [31:0] pend_hi = '0;
  logic [31:0] pend_lo = '0;
  logic        m_done  = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_rem  <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem == 0) begin
        if (bus.start && !bus.flush &&
            (bus.func inside {F_MULT, F_MULTU, F_DIV, F_DIVU})) begin
          m_rem              <= 33;
          {pend_hi, pend_lo} <= ref_result(bus.func, bus.rsData, bus.rtData);
        end
      end else if (bus.flush) begin
        m_rem <= 0;
      end else if (m_rem == 1) begin
        m_rem  <= 0;
        m_hi   <= pend_hi;
        m_lo   <= pend_lo;
        m_done <= 1'b1;
      end else begin
        m_rem <= m_rem - 1;
      end
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      chk("cyc_busy", {31'b0, bus.busy}, {31'b0, (m_rem != 0)});
      chk("cyc_done", {31'b0, bus.done}, {31'b0, m_done});
      chk("cyc_hi", bus.hi, m_hi);
      chk("cyc_lo", bus.lo, m_lo);
    end
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.start  = 1'b1;
    bus.func   = f;
    bus.rsData = a;
    bus.rtData = b;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    while (!bus.done && cycles < 40) begin
      cycles++;
      busy_cycles += int'(bus.busy);
      @(negedge clock);
    end
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input string name, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int c, bc;
    issue(f, a, b);
    wait_done(c, bc);
    chk({name, "_lat"}, c, 33);
    chk({name, "_hi"}, bus.hi, ehi);
    chk({name, "_lo"}, bus.lo, elo);
    $display("op %s rs=%08h rt=%08h -> hi=%08h lo=%08h", name, a, b, bus.hi, bus.lo);
  endtask

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int c, bc, dn;
    int r;
    bus.start  = 1'b0;
    bus.func   = 6'd0;
    bus.rsData = '0;
    bus.rtData = '0;
    bus.flush  = 1'b0;
    repeat (3) @(negedge clock);
    reset_n  = 1'b1;
    check_en = 1'b1;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);

    // Full-scale unsigned multiply with latency and pulse-width checks
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(c, bc);
    chk("multu_max_busy", bc, 33);
    chk("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", bus.lo, 32'h0000_0001);
    $display("op multu_max -> hi=%08h lo=%08h busy=%0d", bus.hi, bus.lo, bc);
    @(negedge clock);
    chk("multu_done_pulse", {31'b0, bus.done}, 32'h0);

    run_vec("mult_neg",  F_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_vec("mult_min",  F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_vec("div_neg",   F_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_vec("divu",      F_DIVU,  32'd7,         32'd2,        32'd1,         32'd3);
    run_vec("div_negd",  F_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD);
    run_vec("divu_zero", F_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF);
    run_vec("div_ovf",   F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000);

    // Start while busy is ignored
    issue(F_MULTU, 32'd3, 32'd4);
    repeat (3) @(negedge clock);
    bus.start = 1'b1; bus.func = F_DIV; bus.rsData = 32'd7; bus.rtData = 32'd2;
    @(negedge clock);
    bus.start = 1'b0;
    wait_done(c, bc);
    chk("ign_hi", bus.hi, 32'h0);
    chk("ign_lo", bus.lo, 32'd12);
    $display("op multu_ignore -> hi=%08h lo=%08h", bus.hi, bus.lo);

    // Flush mid-operation
    issue(F_DIVU, 32'd100, 32'd7);
    repeat (8) @(negedge clock);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    chk("flush_busy", {31'b0, bus.busy}, 32'h0);
    dn = 0;
    repeat (40) begin
      @(negedge clock);
      dn += int'(bus.done);
    end
    chk("flush_no_done", dn, 0);
    chk("flush_hi", bus.hi, 32'h0);
    chk("flush_lo", bus.lo, 32'd12);
    $display("op divu_flush -> hi=%08h lo=%08h dones=%0d", bus.hi, bus.lo, dn);

    // Asynchronous reset mid-operation
    issue(F_MULT, 32'd9, 32'd9);
    repeat (18) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, bus.busy}, 32'h0);
    chk("arst_done", {31'b0, bus.done}, 32'h0);
    chk("arst_hi", bus.hi, 32'h0);
    chk("arst_lo", bus.lo, 32'h0);
    $display("op reset_mid -> busy=%0b hi=%08h lo=%08h", bus.busy, bus.hi, bus.lo);
    @(negedge clock);
    reset_n = 1'b1;

    // Back-to-back: second start issued in the done cycle
    issue(F_MULTU, 32'd2, 32'd3);
    wait_done(c, bc);
    chk("b2b_first_lo", bus.lo, 32'd6);
    bus.start = 1'b1; bus.func = F_DIVU; bus.rsData = 32'd100; bus.rtData = 32'd7;
    @(negedge clock);
    bus.start = 1'b0;
    wait_done(c, bc);
    chk("b2b_gap", c + 1, 34);
    chk("b2b_lo", bus.lo, 32'd14);
    chk("b2b_hi", bus.hi, 32'd2);
    $display("op b2b -> hi=%08h lo=%08h gap=%0d", bus.hi, bus.lo, c + 1);

    // Unrecognized function code
    @(negedge clock);
    bus.start = 1'b1; bus.func = 6'b100000;
    @(negedge clock);
    bus.start = 1'b0;
    chk("badfunc_busy", {31'b0, bus.busy}, 32'h0);
    $display("op badfunc -> busy=%0b", bus.busy);

    // Random traffic: issues, stray starts, flushes, invalid codes
    repeat (3000) begin
      @(negedge clock);
      r          = int'($urandom_range(0, 9));
      bus.start  = ($urandom_range(0, 3) == 0);
      bus.func   = (r == 0) ? 6'b100000 : (6'b011000 | 6'(r % 4));
      bus.rsData = pick_opnd();
      bus.rtData = pick_opnd();
      bus.flush  = ($urandom_range(0, 79) == 0);
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    repeat (40) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/muldiv_hilo_unit.md
# muldiv_hilo_unit

Multi-cycle multiply/divide sequencer owning the HI/LO register pair for the MIPS execute stage. It accepts MULT, MULTU, DIV and DIVU issues from decode alongside the main ALU. It computes the result iteratively with one shared 64-bit shift datapath and holds `busy` so the pipeline stalls dependent MFHI/MFLO. HI/LO are presented continuously to the ALU result mux for MFHI/MFLO.

## Interface
- `WIDTH`, 32: operand width. Only 32 is supported; the iteration count equals `WIDTH`.

- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue strobe from decode; sampled only in IDLE.
- `func`  in  6  R-type function code: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
- `rsData`  in  32  multiplicand or dividend.
- `rtData`  in  32  multiplier or divisor.
- `flush`  in  1  aborts an in-flight operation (branch/exception squash).
- `busy`  out  1  high while an operation is in progress; decode stalls MULT/DIV/MFHI/MFLO on it.
- `done`  out  1  one-cycle pulse in the cycle new HI/LO first become visible.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, CALC, FIXUP.
- IDLE:
  - `start`=1 with a valid `func` latches the operands, the op type and signedness, and clears the counter, then goes to CALC.
  - `start` with any other `func` is ignored.
- Operand latch for signed ops: store |rs| and |rt| as 32-bit unsigned magnitudes. |0x80000000| = 0x80000000.
  - Record `neg_q` = sign(rs) XOR sign(rt).
  - Record `neg_r` = sign(rs).
- CALC runs 32 iterations, one per cycle, with counter 0..31. On counter==31 it goes to FIXUP.
  - Multiply: shift-add into a 64-bit accumulator, LSB-first over the multiplier.
  - Divide: restoring division. Each cycle shifts {rem,quot} left by 1 and trial-subtracts the divisor from the 33-bit remainder. If non-negative, keep the difference and set the quotient LSB.
- FIXUP writes HI/LO, pulses `done`, and returns to IDLE.
  - MULT: negate the 64-bit product if `neg_q`; HI = product[63:32], LO = product[31:0].
  - MULTU: HI/LO taken directly from the 64-bit product.
  - DIV/DIVU: LO = quotient (negated if signed and `neg_q`), HI = remainder (negated if signed and `neg_r`).
  - Divide by zero (rt==0, signed or unsigned): LO = 0xFFFFFFFF, HI = rsData as latched. Full latency still applies.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `start` while `busy`=1 is ignored. There is no queueing, and the operands are not re-latched.
- `flush`:
  - In CALC or FIXUP: go to IDLE at the next edge. HI/LO keep their prior values and `done` stays 0.
  - `flush` takes priority over the FIXUP write in the same cycle.
  - `flush` in IDLE has no effect, and also blocks a simultaneous `start`.
- HI/LO change only on a FIXUP write or on reset.

## Timing
- Reset (`reset_n`=0, asynchronous) forces: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0, operand registers=0.
  - Reset asserted mid-operation discards the operation immediately.
- `start` accepted at edge E0 gives:
  - `busy`=1 from after E0 through the cycle ending at E33.
  - CALC iterations at edges E1..E32.
  - FIXUP write at edge E33.
  - After E33: `busy`=0, `done`=1 for exactly one cycle, and new `hi`/`lo` visible.
- Total latency from issue edge to visible result is 33 cycles; operations are back-to-back capable.
  - A `start` is legal in the cycle `done`=1, which is accepted at E34.
- `busy` is registered: it is a state decode, not a combinational function of `start`.
- `hi`/`lo` are registered outputs and are stable except in the cycle following a FIXUP edge.

## Test plan
- Reset then MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF:
  - `hi`/`lo` read 0 before the operation.
  - After 33 cycles, HI=0xFFFFFFFE, LO=0x00000001, with a single `done` pulse.
  - `busy` is high for exactly 33 cycles.
- Signed multiply:
  - MULT rs=0xFFFFFFFD (-3), rt=7 gives HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - MULT rs=0x80000000, rt=0x80000000 gives HI=0x40000000, LO=0.
- Division:
  - DIV rs=0xFFFFFFF9 (-7), rt=2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU rs=7, rt=2 gives LO=3, HI=1.
  - DIV rs=7, rt=0xFFFFFFFE (-2) gives LO=0xFFFFFFFD, HI=1.
- Division corner cases:
  - DIVU rs=5, rt=0 gives LO=0xFFFFFFFF, HI=5 after 33 cycles.
  - DIV rs=0x80000000, rt=0xFFFFFFFF gives LO=0x80000000, HI=0.
- Control events:
  - Issue MULTU 3×4, pulse `start` with a DIV at cycle 5: it is ignored, and the result is HI=0, LO=12.
  - Issue a new op and assert `flush` at cycle 10: `busy` drops next cycle, there is no `done`, and HI/LO stay 0/12.
  - Issue again and drop `reset_n` at cycle 20: all outputs are 0 immediately.
- Back-to-back: start MULTU 2×3, then start DIVU 100/7 in the `done` cycle:
  - LO=6 after the first operation.
  - LO=14, HI=2 exactly 34 cycles later.
  - Unrecognized `func` 100000 with `start` produces no `busy`.
